// File: rtl/urv_divide_pkg.sv
// Shared divider definitions: RV32M divide funct3 codes, FSM state encoding
// and two's-complement helpers.
package urv_divide_pkg;

    localparam logic [2:0] FUN_DIV  = 3'b100;
    localparam logic [2:0] FUN_DIVU = 3'b101;
    localparam logic [2:0] FUN_REM  = 3'b110;
    localparam logic [2:0] FUN_REMU = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_e;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/urv_divide_if.sv
// Execute-stage divider bus: decoded operands in, stall request and
// writeback result out.
interface urv_divide_if;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        d_valid_i;
    logic [31:0] d_rs1_i;
    logic [31:0] d_rs2_i;
    logic [2:0]  d_fun_i;
    logic        x_stall_req_o;
    logic        w_valid_o;
    logic [31:0] w_rd_o;

    modport slave (
        input  x_stall_i, x_kill_i, d_valid_i, d_rs1_i, d_rs2_i, d_fun_i,
        output x_stall_req_o, w_valid_o, w_rd_o
    );

    modport master (
        output x_stall_i, x_kill_i, d_valid_i, d_rs1_i, d_rs2_i, d_fun_i,
        input  x_stall_req_o, w_valid_o, w_rd_o
    );
endinterface

// File: rtl/urv_div_step.sv
// One restoring-division step: 33-bit trial subtract of the divisor from the
// shifted partial remainder, keeping the difference when it is non-negative.
module urv_div_step (
    input  logic [31:0] rem_i,
    input  logic        msb_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic        q_o
);
    logic [32:0] part;
    logic [32:0] diff;

    assign part  = {rem_i, msb_i};
    assign diff  = part - {1'b0, dvs_i};
    assign q_o   = ~diff[32];
    // On a failed trial the partial remainder is below the divisor, so bit 32 is zero.
    assign rem_o = q_o ? diff[31:0] : part[31:0];
endmodule

// File: rtl/urv_divide.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define URV_DIV_EARLY_OUT_EN to finish divide-by-zero and overflow from SETUP.
module urv_divide
    import urv_divide_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n_i,
    urv_divide_if.slave  bus
);
    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  fun_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic        qsign_q;
    logic        rsign_q;
    logic        dz_q;
    logic        sreq_q;
    logic [31:0] rd_q;

    logic [31:0] rem_d;
    logic        qbit_d;
    logic        accept;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // funct3[2] separates divide codes from multiply codes on the shared decode bus.
    assign accept = bus.d_valid_i & bus.d_fun_i[2] & ~bus.x_stall_i & ~bus.x_kill_i;

    urv_div_step u_step (
        .rem_i (rem_q),
        .msb_i (dvd_q[31]),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    assign quo_fix = (qsign_q & ~dz_q) ? neg32(dvd_q) : dvd_q;
    assign rem_fix = rsign_q ? neg32(rem_q) : rem_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fun_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
            sreq_q  <= 1'b0;
            rd_q    <= '0;
        end else if (state_q != S_IDLE && bus.x_kill_i) begin
            state_q <= S_IDLE;
            sreq_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    fun_q   <= bus.d_fun_i[1:0];
                    dvd_q   <= bus.d_rs1_i;
                    dvs_q   <= bus.d_rs2_i;
                    sreq_q  <= 1'b1;
                    state_q <= S_SETUP;
                end
                S_SETUP: begin
                    if (!fun_q[0]) begin
                        dvd_q   <= abs32(dvd_q);
                        dvs_q   <= abs32(dvs_q);
                        qsign_q <= dvd_q[31] ^ dvs_q[31];
                        rsign_q <= dvd_q[31];
                    end else begin
                        qsign_q <= 1'b0;
                        rsign_q <= 1'b0;
                    end
                    dz_q    <= (dvs_q == '0);
                    rem_q   <= '0;
                    cnt_q   <= 5'd31;
                    state_q <= S_ITER;
`ifdef URV_DIV_EARLY_OUT_EN
                    if (dvs_q == '0) begin
                        rd_q    <= fun_q[1] ? dvd_q : 32'hFFFF_FFFF;
                        state_q <= S_DONE;
                    end else if (!fun_q[0] && dvd_q == 32'h8000_0000 && dvs_q == 32'hFFFF_FFFF) begin
                        rd_q    <= fun_q[1] ? 32'd0 : 32'h8000_0000;
                        state_q <= S_DONE;
                    end
`endif
                end
                S_ITER: begin
                    // The dividend register shifts out its MSB and collects quotient bits.
                    rem_q <= rem_d;
                    dvd_q <= {dvd_q[30:0], qbit_d};
                    cnt_q <= cnt_q - 5'd1;
                    if (cnt_q == 5'd0) state_q <= S_FIX;
                end
                S_FIX: begin
                    rd_q    <= fun_q[1] ? rem_fix : quo_fix;
                    state_q <= S_DONE;
                end
                S_DONE: if (!bus.x_stall_i) begin
                    sreq_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // The strobe is suppressed while writeback is stalled or the op is flushed.
    assign bus.w_valid_o     = (state_q == S_DONE) & ~bus.x_stall_i & ~bus.x_kill_i;
    assign bus.x_stall_req_o = sreq_q;
    assign bus.w_rd_o        = rd_q;
endmodule

// File: tb/tb_urv_divide.sv
// Scoreboard bench for urv_divide: expected results are queued at issue and
// compared when the w_valid_o strobe appears.
module tb_urv_divide;
    import urv_divide_pkg::*;

`ifdef URV_DIV_EARLY_OUT_EN
    localparam int LAT_SPEC = 2;
`else
    localparam int LAT_SPEC = 35;
`endif
    localparam int LAT = 35;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    urv_divide_if bus ();

    urv_divide dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!f[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return f[1] ? r : q;
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int st_from, input int st_to, input string nm);
        int   cyc;
        logic got;
        logic sreq_bad;
        logic [31:0] exp;
        @(negedge clk);
        bus.d_valid_i = 1'b1;
        bus.d_fun_i   = f;
        bus.d_rs1_i   = a;
        bus.d_rs2_i   = b;
        exp_q.push_back(model(f, a, b));
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        sreq_bad = 1'b0;
        while (!got && cyc < 100) begin
            @(negedge clk);
            cyc++;
            bus.d_valid_i = 1'b0;
            bus.x_stall_i = (cyc >= st_from && cyc <= st_to);
            #1;
            if (bus.x_stall_req_o !== 1'b1) sreq_bad = 1'b1;
            if (bus.w_valid_o === 1'b1) begin
                got = 1'b1;
                exp = exp_q.pop_front();
                last_rd = exp;
                checks++;
                if (bus.w_rd_o !== exp) begin
                    errors++;
                    $display("FAIL %s result: got %h expected %h", nm, bus.w_rd_o, exp);
                end
            end
        end
        bus.x_stall_i = 1'b0;
        if (!got) void'(exp_q.pop_front());
        checks++;
        if (!got || cyc != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (valid=%0d) expected %0d", nm, cyc, got, lat);
        end
        checks++;
        if (sreq_bad) begin
            errors++;
            $display("FAIL %s stall_req: dropped before result, expected high cycles 1..%0d", nm, lat);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.w_valid_o !== 1'b0 || bus.x_stall_req_o !== 1'b0 || bus.w_rd_o !== last_rd) begin
            errors++;
            $display("FAIL %s idle: valid=%b sreq=%b rd=%h expected 0 0 %h",
                     nm, bus.w_valid_o, bus.x_stall_req_o, bus.w_rd_o, last_rd);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.x_stall_i = 1'b0;
        bus.x_kill_i  = 1'b0;
        bus.d_valid_i = 1'b0;
        bus.d_rs1_i   = '0;
        bus.d_rs2_i   = '0;
        bus.d_fun_i   = FUN_DIVU;
        last_rd = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.w_valid_o !== 1'b0 || bus.x_stall_req_o !== 1'b0 || bus.w_rd_o !== 32'd0) begin
            errors++;
            $display("FAIL reset: valid=%b sreq=%b rd=%h expected 0 0 0",
                     bus.w_valid_o, bus.x_stall_req_o, bus.w_rd_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        do_op(FUN_DIVU, 32'd100, 32'd7, LAT, 99, 0, "divu_100_7");
        do_op(FUN_REMU, 32'd100, 32'd7, LAT, 99, 0, "remu_100_7");
        do_op(FUN_DIVU, 32'hFFFF_FFFF, 32'd1, LAT, 99, 0, "divu_max_1");
        do_op(FUN_REMU, 32'hFFFF_FFF0, 32'hFFFF_FFFF, LAT, 99, 0, "remu_small_big");
    endtask

    task automatic test_signed;
        do_op(FUN_DIV, 32'hFFFF_FFF9, 32'd2, LAT, 99, 0, "div_m7_2");
        do_op(FUN_REM, 32'hFFFF_FFF9, 32'd2, LAT, 99, 0, "rem_m7_2");
        do_op(FUN_REM, 32'd7, 32'hFFFF_FFFE, LAT, 99, 0, "rem_7_m2");
        do_op(FUN_DIV, 32'd7, 32'hFFFF_FFFE, LAT, 99, 0, "div_7_m2");
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a, b;
            logic [2:0]  f;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 24);
            if (b == 32'd0) b = 32'd3;
            f = {1'b1, 2'($urandom_range(0, 3))};
            do_op(f, a, b, LAT, 99, 0, "random");
        end
    endtask

    task automatic test_div_zero;
        do_op(FUN_DIV,  32'd5, 32'd0, LAT_SPEC, 99, 0, "div_5_0");
        do_op(FUN_REMU, 32'd5, 32'd0, LAT_SPEC, 99, 0, "remu_5_0");
        do_op(FUN_DIV,  32'hFFFF_FFFB, 32'd0, LAT_SPEC, 99, 0, "div_m5_0");
        do_op(FUN_REM,  32'hFFFF_FFFB, 32'd0, LAT_SPEC, 99, 0, "rem_m5_0");
    endtask

    task automatic test_overflow;
        do_op(FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPEC, 99, 0, "div_ovf");
        do_op(FUN_REM, 32'h8000_0000, 32'hFFFF_FFFF, LAT_SPEC, 99, 0, "rem_ovf");
        do_op(FUN_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 99, 0, "divu_no_ovf");
    endtask

    task automatic test_kill;
        logic seen;
        @(negedge clk);
        bus.d_valid_i = 1'b1;
        bus.d_fun_i   = FUN_DIVU;
        bus.d_rs1_i   = 32'h1234_5678;
        bus.d_rs2_i   = 32'd3;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.d_valid_i = 1'b0;
            bus.x_kill_i  = (c == 10);
        end
        @(negedge clk);
        bus.x_kill_i = 1'b0;
        #1;
        checks++;
        if (bus.x_stall_req_o !== 1'b0 || bus.w_valid_o !== 1'b0 || bus.w_rd_o !== last_rd) begin
            errors++;
            $display("FAIL kill: sreq=%b valid=%b rd=%h expected 0 0 %h",
                     bus.x_stall_req_o, bus.w_valid_o, bus.w_rd_o, last_rd);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.w_valid_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL kill_no_valid: got w_valid_o=1 after kill, expected none");
        end
        do_op(FUN_DIVU, 32'd9, 32'd3, LAT, 99, 0, "divu_after_kill");
    endtask

    task automatic test_stall;
        do_op(FUN_DIVU, 32'd100, 32'd7, 38, 35, 37, "divu_stalled");
        do_op(FUN_REM, 32'hFFFF_FF00, 32'd7, 36, 35, 35, "rem_stalled");
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.d_valid_i = 1'b1;
        bus.d_fun_i   = FUN_DIVU;
        bus.d_rs1_i   = 32'd1000;
        bus.d_rs2_i   = 32'd9;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            bus.d_valid_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.x_stall_req_o !== 1'b0 || bus.w_valid_o !== 1'b0 || bus.w_rd_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: sreq=%b valid=%b rd=%h expected 0 0 0",
                     bus.x_stall_req_o, bus.w_valid_o, bus.w_rd_o);
        end
        last_rd = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(FUN_DIVU, 32'd1000, 32'd9, LAT, 99, 0, "divu_after_reset");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_kill();
        test_stall();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
